// File: rtl/rr_arb16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: state encoding,
// parameter defaults and the rotating priority search.
package rr_arb16_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int unsigned MAXHOLD_DEFAULT = 8;
   localparam int unsigned NREQ            = 16;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } pick_t;

   // First set request scanning ptr, ptr+1, ... with 4-bit wrap-around.
   function automatic pick_t rr_pick(input logic [0:15] req, input logic [3:0] ptr);
      pick_t      p;
      logic [3:0] idx;
      p = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = ptr + 4'(k);
         if (!p.found && req[idx]) begin
            p.found = 1'b1;
            p.idx   = idx;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_arb16_dec4to16.sv
// 4-to-16 one-hot decoder with enable; output bit i is set when En=1 and A=i.
module dec4to16 (
   input  logic [3:0]  A,
   input  logic        En,
   output logic [0:15] Y
);

   always_comb begin
      Y = '0;
      if (En) Y[A] = 1'b1;
   end

endmodule

// File: rtl/rr_arb16.sv
// 16-way round-robin arbiter with per-grant hold limit and forced-release pulse.
// Y is decoded from the registered grant index and valid.
module rr_arb16
   import rr_arb16_pkg::*;
#(
   parameter int unsigned MAXHOLD = MAXHOLD_DEFAULT
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic [0:15] Req,
   input  logic        Done,
   output logic [3:0]  W,
   output logic        En,
   output logic [0:15] Y,
   output logic        Timeout
);

   localparam logic [3:0] HOLD_LAST = 4'(MAXHOLD - 1);

   state_t     state_q, state_d;
   logic [3:0] w_q, w_d;
   logic [3:0] ptr_q, ptr_d;
   logic [3:0] hold_q, hold_d;
   logic       to_q, to_d;
   pick_t      pick;
   logic       rel_normal, hold_hit;

   assign pick = rr_pick(Req, ptr_q);

   always_comb begin
      rel_normal = Done || !Req[w_q];
      hold_hit   = (hold_q == HOLD_LAST);
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (pick.found) state_d = GRANT;
         GRANT: if (rel_normal || hold_hit) state_d = IDLE;
      endcase
   end

   // A hold-limit release only counts as a timeout when no normal release coincides.
   always_comb begin
      w_d    = w_q;
      ptr_d  = ptr_q;
      hold_d = hold_q;
      to_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick.found) begin
               w_d    = pick.idx;
               hold_d = '0;
            end
         end
         GRANT: begin
            if (rel_normal || hold_hit) begin
               ptr_d = w_q + 4'd1;
               to_d  = hold_hit && !rel_normal;
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         w_q    <= '0;
         ptr_q  <= '0;
         hold_q <= '0;
         to_q   <= 1'b0;
      end else begin
         w_q    <= w_d;
         ptr_q  <= ptr_d;
         hold_q <= hold_d;
         to_q   <= to_d;
      end
   end

   assign W       = w_q;
   assign En      = (state_q == GRANT);
   assign Timeout = to_q;

   dec4to16 u_dec (
      .A  (w_q),
      .En (En),
      .Y  (Y)
   );

endmodule

// File: tb/tb_rr_arb16.sv
// Self-checking bench for rr_arb16: directed scenarios plus randomized traffic
// compared against a behavioural arbiter model, for MAXHOLD=4 and MAXHOLD=1.
module tb_rr_arb16;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic [0:15] Req = '0;
   logic        Done = 1'b0;

   logic [3:0]  w4, w1;
   logic        en4, en1, to4, to1;
   logic [0:15] y4, y1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      bit          gnt;
      int unsigned w;
      int unsigned ptr;
      int unsigned cnt;
      bit          to;
   } mstate_t;

   localparam mstate_t MRESET = '{gnt: 1'b0, w: 0, ptr: 0, cnt: 0, to: 1'b0};

   mstate_t m4 = MRESET;
   mstate_t m1 = MRESET;

   rr_arb16 #(.MAXHOLD(4)) u_dut4 (
      .Clock(Clock), .Resetn(Resetn), .Req(Req), .Done(Done),
      .W(w4), .En(en4), .Y(y4), .Timeout(to4)
   );

   rr_arb16 #(.MAXHOLD(1)) u_dut1 (
      .Clock(Clock), .Resetn(Resetn), .Req(Req), .Done(Done),
      .W(w1), .En(en1), .Y(y1), .Timeout(to1)
   );

   always #5 Clock = ~Clock;

   // cnt = number of grant cycles already spent on the current grant.
   function automatic mstate_t mstep(mstate_t s, logic [0:15] req, logic done, int unsigned maxhold);
      mstate_t n;
      n    = s;
      n.to = 1'b0;
      if (s.gnt) begin
         if (done || !req[s.w]) begin
            n.gnt = 1'b0;
            n.ptr = (s.w + 1) % 16;
         end else if (s.cnt == maxhold) begin
            n.gnt = 1'b0;
            n.ptr = (s.w + 1) % 16;
            n.to  = 1'b1;
         end else begin
            n.cnt = s.cnt + 1;
         end
      end else begin
         for (int k = 0; k < 16; k++) begin
            if (req[(s.ptr + k) % 16]) begin
               n.gnt = 1'b1;
               n.w   = (s.ptr + k) % 16;
               n.cnt = 1;
               break;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [0:15] yexp(bit gnt, int unsigned w);
      logic [0:15] y;
      for (int i = 0; i < 16; i++) y[i] = gnt && (i == w);
      return y;
   endfunction

   // Drive at the falling edge, step the model at the rising edge, return at the next falling edge.
   task automatic cycle(input logic [0:15] r, input logic d);
      Req  = r;
      Done = d;
      @(posedge Clock);
      m4 = mstep(m4, r, d, 4);
      m1 = mstep(m1, r, d, 1);
      @(negedge Clock);
   endtask

   task automatic apply_reset();
      Req    = '0;
      Done   = 1'b0;
      Resetn = 1'b0;
      m4     = MRESET;
      m1     = MRESET;
      @(negedge Clock);
      @(negedge Clock);
      Resetn = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (w4 !== 4'd0 || en4 !== 1'b0 || y4 !== 16'h0000 || to4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dut4: W=%0d En=%b Y=%h Timeout=%b, required 0 0 0000 0", w4, en4, y4, to4);
      end
      checks++;
      if (w1 !== 4'd0 || en1 !== 1'b0 || y1 !== 16'h0000 || to1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dut1: W=%0d En=%b Y=%h Timeout=%b, required 0 0 0000 0", w1, en1, y1, to1);
      end
   endtask

   task automatic test_single();
      logic [0:15] r, ey;
      apply_reset();
      r = '0; r[3] = 1'b1;
      ey = '0; ey[3] = 1'b1;
      cycle(r, 1'b0);
      checks++;
      if (w4 !== 4'd3 || en4 !== 1'b1 || y4 !== ey) begin
         errors++;
         $display("FAIL single_grant: W=%0d En=%b Y=%h, required 3 1 %h", w4, en4, y4, ey);
      end
      cycle(r, 1'b1);
      checks++;
      if (en4 !== 1'b0 || y4 !== 16'h0000 || to4 !== 1'b0) begin
         errors++;
         $display("FAIL single_release: En=%b Y=%h Timeout=%b, required 0 0000 0", en4, y4, to4);
      end
      cycle('0, 1'b1);
      checks++;
      if (w4 !== 4'd3 || en4 !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold_w: W=%0d En=%b, required 3 0", w4, en4);
      end
   endtask

   task automatic test_round_robin();
      logic [0:15] r;
      int unsigned exp_w[4] = '{2, 9, 2, 9};
      apply_reset();
      r = '0; r[2] = 1'b1; r[9] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(r, 1'b0);
         checks++;
         if (en4 !== 1'b1 || w4 !== 4'(exp_w[i])) begin
            errors++;
            $display("FAIL rr_grant%0d: En=%b W=%0d, required 1 %0d", i, en4, w4, exp_w[i]);
         end
         cycle(r, 1'b1);
         checks++;
         if (en4 !== 1'b0) begin
            errors++;
            $display("FAIL rr_gap%0d: En=%b, required 0", i, en4);
         end
      end
   endtask

   task automatic test_wrap();
      logic [0:15] r;
      apply_reset();
      r = '0; r[14] = 1'b1;
      cycle(r, 1'b0);
      checks++;
      if (en4 !== 1'b1 || w4 !== 4'd14) begin
         errors++;
         $display("FAIL wrap_g14: En=%b W=%0d, required 1 14", en4, w4);
      end
      cycle(r, 1'b1);
      r = '0; r[0] = 1'b1; r[15] = 1'b1;
      cycle(r, 1'b0);
      checks++;
      if (en4 !== 1'b1 || w4 !== 4'd15) begin
         errors++;
         $display("FAIL wrap_g15: En=%b W=%0d, required 1 15", en4, w4);
      end
      cycle(r, 1'b1);
      cycle(r, 1'b0);
      checks++;
      if (en4 !== 1'b1 || w4 !== 4'd0) begin
         errors++;
         $display("FAIL wrap_g0: En=%b W=%0d, required 1 0", en4, w4);
      end
   endtask

   task automatic test_hold_limit();
      logic [0:15] r;
      apply_reset();
      r = '0; r[7] = 1'b1;
      cycle(r, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         checks++;
         if (en4 !== 1'b1 || w4 !== 4'd7 || to4 !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: En=%b W=%0d Timeout=%b, required 1 7 0", i, en4, w4, to4);
         end
         cycle(r, 1'b0);
      end
      checks++;
      if (en4 !== 1'b1 || to4 !== 1'b0) begin
         errors++;
         $display("FAIL hold_cycle4: En=%b Timeout=%b, required 1 0", en4, to4);
      end
      r[12] = 1'b1;
      cycle(r, 1'b0);
      checks++;
      if (en4 !== 1'b0 || to4 !== 1'b1) begin
         errors++;
         $display("FAIL hold_timeout: En=%b Timeout=%b, required 0 1", en4, to4);
      end
      cycle(r, 1'b0);
      checks++;
      if (en4 !== 1'b1 || w4 !== 4'd12 || to4 !== 1'b0) begin
         errors++;
         $display("FAIL hold_next_ptr: En=%b W=%0d Timeout=%b, required 1 12 0", en4, w4, to4);
      end
   endtask

   task automatic test_simultaneous();
      logic [0:15] r;
      apply_reset();
      r = '0; r[7] = 1'b1;
      for (int i = 0; i < 4; i++) cycle(r, 1'b0);
      checks++;
      if (en4 !== 1'b1) begin
         errors++;
         $display("FAIL simul_pre: En=%b, required 1", en4);
      end
      cycle(r, 1'b1);
      checks++;
      if (en4 !== 1'b0 || to4 !== 1'b0) begin
         errors++;
         $display("FAIL simul_release: En=%b Timeout=%b, required 0 0", en4, to4);
      end
   endtask

   task automatic test_maxhold1();
      logic [0:15] r;
      apply_reset();
      r = '0; r[6] = 1'b1;
      cycle(r, 1'b0);
      checks++;
      if (en1 !== 1'b1 || w1 !== 4'd6) begin
         errors++;
         $display("FAIL mh1_grant: En=%b W=%0d, required 1 6", en1, w1);
      end
      cycle(r, 1'b0);
      checks++;
      if (en1 !== 1'b0 || to1 !== 1'b1) begin
         errors++;
         $display("FAIL mh1_release: En=%b Timeout=%b, required 0 1", en1, to1);
      end
      cycle(r, 1'b0);
      checks++;
      if (en1 !== 1'b1 || w1 !== 4'd6 || to1 !== 1'b0) begin
         errors++;
         $display("FAIL mh1_regrant: En=%b W=%0d Timeout=%b, required 1 6 0", en1, w1, to1);
      end
   endtask

   task automatic test_reset_mid_grant();
      logic [0:15] r;
      apply_reset();
      r = '0; r[5] = 1'b1;
      for (int i = 0; i < 2; i++) cycle(r, 1'b0);
      checks++;
      if (en4 !== 1'b1 || w4 !== 4'd5) begin
         errors++;
         $display("FAIL rst_mid_pre: En=%b W=%0d, required 1 5", en4, w4);
      end
      #2;
      Resetn = 1'b0;
      m4 = MRESET;
      m1 = MRESET;
      #1;
      checks++;
      if (en4 !== 1'b0 || y4 !== 16'h0000 || w4 !== 4'd0 || to4 !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_async: En=%b Y=%h W=%0d Timeout=%b, required 0 0000 0 0", en4, y4, w4, to4);
      end
      @(negedge Clock);
      @(negedge Clock);
      Resetn = 1'b1;
      r[1] = 1'b1;
      cycle(r, 1'b0);
      checks++;
      if (en4 !== 1'b1 || w4 !== 4'd1) begin
         errors++;
         $display("FAIL rst_mid_regrant: En=%b W=%0d, required 1 1", en4, w4);
      end
   endtask

   task automatic test_random();
      logic [0:15] r;
      logic        d;
      apply_reset();
      r = '0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0: r = '0;
               1: begin r = '0; r[$urandom_range(0, 15)] = 1'b1; end
               2: begin r = '0; r[$urandom_range(0, 15)] = 1'b1; r[$urandom_range(0, 15)] = 1'b1; end
               default: r = 16'($urandom);
            endcase
         end
         d = ($urandom_range(0, 5) == 0);
         cycle(r, d);
         checks++;
         if (en4 !== m4.gnt || y4 !== yexp(m4.gnt, m4.w) || to4 !== m4.to) begin
            errors++;
            $display("FAIL rand4_%0d: En=%b Y=%h Timeout=%b, required %b %h %b", n, en4, y4, to4, m4.gnt, yexp(m4.gnt, m4.w), m4.to);
         end
         checks++;
         if (w4 !== 4'(m4.w)) begin
            errors++;
            $display("FAIL rand4_w_%0d: W=%0d, required %0d", n, w4, m4.w);
         end
         checks++;
         if (en1 !== m1.gnt || y1 !== yexp(m1.gnt, m1.w) || to1 !== m1.to) begin
            errors++;
            $display("FAIL rand1_%0d: En=%b Y=%h Timeout=%b, required %b %h %b", n, en1, y1, to1, m1.gnt, yexp(m1.gnt, m1.w), m1.to);
         end
         checks++;
         if (w1 !== 4'(m1.w)) begin
            errors++;
            $display("FAIL rand1_w_%0d: W=%0d, required %0d", n, w1, m1.w);
         end
      end
   endtask

   initial begin
      @(negedge Clock);
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_hold_limit();
      test_simultaneous();
      test_maxhold1();
      test_reset_mid_grant();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
